// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the adc_sampler capture front end.
// Holds the DRP read FSM states, sample widths and the 12-bit saturation helper.
package adc_sampler_pkg;

    localparam int SAMPLE_W = 12;
    localparam int PCM_W    = 8;
    localparam int DC_ACC_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Clamp a one-bit-wider signed value into the signed SAMPLE_W range.
    // Overflow shows up as the two top bits disagreeing.
    function automatic logic [SAMPLE_W-1:0] sat_sample(
        input logic [SAMPLE_W:0] v
    );
        if (v[SAMPLE_W] == v[SAMPLE_W-1]) begin
            return v[SAMPLE_W-1:0];
        end
        return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                           : {1'b0, {(SAMPLE_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/dc_blocker.sv
// DC-blocking high-pass stage: y = sat(x - acc[19:8]), acc += x - dc.
// Ports: clk, rst_n (async, active-low), in_valid/x in, out_valid/y out (one register stage).
module dc_blocker
    import adc_sampler_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] x,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] y
);

    logic [DC_ACC_W-1:0] acc;
    logic [SAMPLE_W-1:0] dc;
    logic [SAMPLE_W:0]   diff;
    logic [DC_ACC_W-1:0] diff_ext;

    // The running DC estimate is the accumulator scaled down by 256.
    assign dc       = acc[DC_ACC_W-1 -: SAMPLE_W];
    assign diff     = {x[SAMPLE_W-1], x} - {dc[SAMPLE_W-1], dc};
    assign diff_ext = {{(DC_ACC_W-SAMPLE_W-1){diff[SAMPLE_W]}}, diff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y   <= sat_sample(diff);
                acc <= acc + diff_ext;
            end
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// 48 kHz XADC capture: paces DRP reads from a free-running counter, converts to signed PCM.
// Ports: clk_in, rst_in_n, enable_in, drp_* handshake, sample_wide_out/sample_out/sample_valid_out,
// timeout_out (sticky), drop_count_out (saturating). Option macro: ADC_SAMPLER_DCBLOCK_EN.
module adc_sampler
    import adc_sampler_pkg::*;
#(
    parameter int unsigned SAMPLE_COUNT = 2082,
    parameter logic [6:0]  DRP_ADDR     = 7'h13,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                enable_in,
    output logic                drp_den_out,
    output logic [6:0]          drp_daddr_out,
    input  logic [15:0]         drp_do_in,
    input  logic                drp_drdy_in,
    output logic [SAMPLE_W-1:0] sample_wide_out,
    output logic [PCM_W-1:0]    sample_out,
    output logic                sample_valid_out,
    output logic                timeout_out,
    output logic [7:0]          drop_count_out
);

    localparam int CNT_W  = (SAMPLE_COUNT > 0) ? $clog2(SAMPLE_COUNT + 1) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SAMPLE_COUNT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]    tick_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [SAMPLE_W-1:0] raw_q;
    logic                raw_vld_q;
    logic                timeout_q;
    logic [7:0]          drop_q;

    logic tick;
    logic accept;
    logic expire;
    logic drop;
    logic unused_lsb;

    assign tick   = (tick_cnt == CNT_MAX);
    assign accept = (state_q == WAIT) && drp_drdy_in;
    // Data arriving in the last allowed cycle still wins over the timeout.
    assign expire = (state_q == WAIT) && !drp_drdy_in && (wait_cnt == WAIT_MAX);
    assign drop   = tick && (state_q != IDLE);

    assign unused_lsb = ^drp_do_in[3:0];

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick && enable_in) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT:    if (accept || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drp_den_out = (state_q == REQ);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            tick_cnt  <= '0;
            wait_cnt  <= '0;
            raw_q     <= '0;
            raw_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            raw_vld_q <= accept;
            if (accept) begin
                // Offset binary to two's complement: flip the MSB.
                raw_q <= {~drp_do_in[15], drp_do_in[14:4]};
            end
            if (state_q == REQ) begin
                wait_cnt <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

`ifdef ADC_SAMPLER_DCBLOCK_EN
    dc_blocker u_dc_blocker (
        .clk       (clk_in),
        .rst_n     (rst_in_n),
        .in_valid  (raw_vld_q),
        .x         (raw_q),
        .out_valid (sample_valid_out),
        .y         (sample_wide_out)
    );
`else
    assign sample_wide_out  = raw_q;
    assign sample_valid_out = raw_vld_q;
`endif

    assign sample_out     = sample_wide_out[SAMPLE_W-1 -: PCM_W];
    assign drp_daddr_out  = DRP_ADDR;
    assign timeout_out    = timeout_q;
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: two instances (TIMEOUT 8 and 64), SAMPLE_COUNT 9.
// Expected samples come from an arithmetic offset-binary model plus an optional DC-block model.
module tb_adc_sampler;

    localparam int SC = 9;
`ifdef ADC_SAMPLER_DCBLOCK_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int MAX_DLY = 9 - LAT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en;
    logic        a_den, b_den, a_drdy, b_drdy;
    logic [6:0]  a_addr, b_addr;
    logic [15:0] a_do, b_do;
    logic [11:0] a_wide, b_wide;
    logic [7:0]  a_pcm, b_pcm, a_drop, b_drop;
    logic        a_valid, b_valid, a_to, b_to;

    int checks = 0;
    int failures = 0;
    int a_vcnt = 0;
    int b_vcnt = 0;
    int a_dcnt = 0;
    int acc_m[2] = '{0, 0};

    adc_sampler #(.SAMPLE_COUNT(SC), .DRP_ADDR(7'h13), .TIMEOUT(8)) dut_a (
        .clk_in(clk), .rst_in_n(rst_n), .enable_in(en),
        .drp_den_out(a_den), .drp_daddr_out(a_addr),
        .drp_do_in(a_do), .drp_drdy_in(a_drdy),
        .sample_wide_out(a_wide), .sample_out(a_pcm),
        .sample_valid_out(a_valid), .timeout_out(a_to),
        .drop_count_out(a_drop)
    );

    adc_sampler #(.SAMPLE_COUNT(SC), .DRP_ADDR(7'h13), .TIMEOUT(64)) dut_b (
        .clk_in(clk), .rst_in_n(rst_n), .enable_in(en),
        .drp_den_out(b_den), .drp_daddr_out(b_addr),
        .drp_do_in(b_do), .drp_drdy_in(b_drdy),
        .sample_wide_out(b_wide), .sample_out(b_pcm),
        .sample_valid_out(b_valid), .timeout_out(b_to),
        .drop_count_out(b_drop)
    );

    always @(posedge clk) begin
        if (a_valid) a_vcnt++;
        if (b_valid) b_vcnt++;
        if (a_den) a_dcnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raw code c in [15:4] represents c-2048; the optional filter removes a slow mean.
    function automatic int model_sample(input bit on_b, input logic [15:0] d);
        int x, dc, y;
        x = int'(d[15:4]) - 2048;
        dc = acc_m[int'(on_b)] >>> 8;
        y = x - dc;
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        acc_m[int'(on_b)] = ((acc_m[int'(on_b)] + x - dc) <<< 12) >>> 12;
`ifdef ADC_SAMPLER_DCBLOCK_EN
        return y;
`else
        return x;
`endif
    endfunction

    task automatic read_x(input bit on_b, input logic [15:0] d, input int dly,
                          input bit drop_en, input bit noise, output int waited);
        int e, v0;
        v0 = on_b ? b_vcnt : a_vcnt;
        if (noise) begin
            if (on_b) begin b_drdy = 1'b1; b_do = 16'hABC0; end
            else begin a_drdy = 1'b1; a_do = 16'hABC0; end
        end
        waited = 0;
        while (!(on_b ? b_den : a_den) && waited < 40) begin
            step();
            waited++;
        end
        chk("den_seen", 32'(waited < 40), 1);
        if (drop_en) en = 1'b0;
        if (noise) begin
            step();
            a_drdy = 1'b0;
            b_drdy = 1'b0;
        end
        repeat (noise ? dly - 1 : dly) step();
        chk("valid_early", on_b ? b_valid : a_valid, 0);
        if (on_b) begin b_drdy = 1'b1; b_do = d; end
        else begin a_drdy = 1'b1; a_do = d; end
        step();
        a_drdy = 1'b0;
        b_drdy = 1'b0;
        a_do = 16'($urandom);
        b_do = 16'($urandom);
        repeat (LAT - 1) begin
            chk("valid_latency", on_b ? b_valid : a_valid, 0);
            step();
        end
        e = model_sample(on_b, d);
        chk("valid", on_b ? b_valid : a_valid, 1);
        chk("sample_wide", on_b ? b_wide : a_wide, 32'(e) & 32'hFFF);
        chk("sample_pcm", on_b ? b_pcm : a_pcm, 32'(e >>> 4) & 32'hFF);
        step();
        chk("valid_pulse", on_b ? b_valid : a_valid, 0);
        chk("valid_count", (on_b ? b_vcnt : a_vcnt) - v0, 1);
    endtask

    initial begin
        int n, v0, d0, drops;
        rst_n = 1'b0;
        en = 1'b1;
        a_drdy = 1'b0;
        b_drdy = 1'b0;
        a_do = '0;
        b_do = '0;
        repeat (3) step();

        chk("rst_den", a_den, 0);
        chk("rst_daddr_a", a_addr, 7'h13);
        chk("rst_daddr_b", b_addr, 7'h13);
        chk("rst_wide", a_wide, 0);
        chk("rst_pcm", a_pcm, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_timeout", a_to, 0);
        chk("rst_drop", a_drop, 0);

        rst_n = 1'b1;
        n = 0;
        while (!a_den && n < 40) begin
            step();
            n++;
        end
        chk("first_den_edge", n + 1, SC + 2);

        read_x(0, 16'h0000, 3, 0, 0, n);
        read_x(0, 16'hFFF0, 3, 0, 0, n);
        read_x(0, 16'h8000, 3, 0, 0, n);
        read_x(0, 16'($urandom), 1, 0, 0, n);
        read_x(0, 16'($urandom), MAX_DLY, 0, 0, n);
        for (int i = 0; i < 8; i++) begin
            read_x(0, 16'($urandom), $urandom_range(2, MAX_DLY), 0, i[0], n);
        end
        chk("no_drop_a", a_drop, 0);
        chk("no_timeout_a", a_to, 0);

        n = 0;
        while (!a_den && n < 40) begin
            step();
            n++;
        end
        chk("to_den", 32'(n < 40), 1);
        v0 = a_vcnt;
        repeat (8) step();
        chk("to_not_yet", a_to, 0);
        step();
        chk("to_set", a_to, 1);
        read_x(0, 16'($urandom), 4, 0, 0, n);
        chk("to_next_den", n, 1);
        chk("to_valids", a_vcnt - v0, 1);
        chk("to_sticky", a_to, 1);
        chk("to_no_drop", a_drop, 0);

        en = 1'b0;
        v0 = a_vcnt;
        d0 = a_dcnt;
        repeat (5 * (SC + 1)) step();
        chk("en_no_den", a_dcnt - d0, 0);
        chk("en_no_valid", a_vcnt - v0, 0);
        chk("en_drop", a_drop, 0);
        en = 1'b1;
        read_x(0, 16'($urandom), 3, 0, 0, n);
        chk("en_resume", 32'(n <= SC + 1), 1);
        read_x(0, 16'($urandom), 5, 1, 0, n);
        en = 1'b1;

        n = 0;
        while (!a_den && n < 40) begin
            step();
            n++;
        end
        chk("mr_den", 32'(n < 40), 1);
        repeat (2) step();
        v0 = a_vcnt;
        rst_n = 1'b0;
        step();
        chk("mr_den_low", a_den, 0);
        chk("mr_timeout_clr", a_to, 0);
        chk("mr_wide_clr", a_wide, 0);
        acc_m = '{0, 0};
        rst_n = 1'b1;
        a_drdy = 1'b1;
        a_do = 16'h7770;
        step();
        a_drdy = 1'b0;
        n = 1;
        while (!a_den && n < 40) begin
            step();
            n++;
        end
        chk("mr_restart", n, SC + 1);
        chk("mr_no_valid", a_vcnt - v0, 0);

        drops = 0;
        for (int i = 0; i < 300; i++) begin
            read_x(1, 16'($urandom), 15, 0, 0, n);
            drops += (1 + 15) / (SC + 1);
            if (drops > 255) drops = 255;
            if (i == 0) chk("drop_first", b_drop, 1);
        end
        chk("drop_sat", b_drop, drops);
        chk("drop_no_timeout", b_to, 0);

`ifdef ADC_SAMPLER_DCBLOCK_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        acc_m = '{0, 0};
        for (int i = 0; i < 2000; i++) begin
            read_x(0, 16'h9000, 3, 0, 0, n);
            if (i == 0) chk("dc_first", a_wide, 12'd256);
        end
        chk("dc_settled",
            32'(($signed(a_wide) < 12'sd4) && ($signed(a_wide) > -12'sd4)), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
